// File: rtl/qdr_usr_tester_pkg.sv
// Shared types and helpers for the QDR user-port traffic tester:
// FSM states, status-bit positions and the address-derived burst pattern.
package qdr_usr_tester_pkg;

  localparam int QDR_DW = 36;
  localparam int QDR_AW = 22;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_PASS    = 2;
  localparam int ST_TIMEOUT = 3;
  localparam int ST_ABORTED = 4;
  localparam int ST_W       = 5;

  function automatic logic [ST_W-1:0] status_word(input logic i_busy, input logic i_done,
                                                  input logic i_pass, input logic i_tmo,
                                                  input logic i_abrt);
    logic [ST_W-1:0] w_s;
    w_s             = {ST_W{1'b0}};
    w_s[ST_BUSY]    = i_busy;
    w_s[ST_DONE]    = i_done;
    w_s[ST_PASS]    = i_pass;
    w_s[ST_TIMEOUT] = i_tmo;
    w_s[ST_ABORTED] = i_abrt;
    return w_s;
  endfunction

  // Low half is the seeded address, high half its complement, so every data bit toggles.
  function automatic logic [2*QDR_DW-1:0] burst(input logic [QDR_AW-1:0] i_addr,
                                                input logic [QDR_DW-1:0] i_seed);
    logic [QDR_DW-1:0] w_p;
    w_p = {{(QDR_DW-QDR_AW){1'b0}}, i_addr} ^ i_seed;
    return {~w_p, w_p};
  endfunction

endpackage

// File: rtl/qdr_usr_tester_fifo.sv
// Outstanding-read address FIFO: show-ahead head, full/empty flags,
// simultaneous push/pop and a synchronous flush.
module qdr_usr_tester_fifo #(
  parameter int WIDTH      = 22,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full  = (r_count == DEPTH_CNT);
  assign o_empty = (r_count == {(DEPTH_LOG2+1){1'b0}});
  assign o_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_do_push = i_push && !o_full;
    w_do_pop  = i_pop && !o_empty;
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= {DEPTH_LOG2{1'b0}};
      r_rd_ptr <= {DEPTH_LOG2{1'b0}};
      r_count  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/qdr_usr_tester.sv
// QDR user-port traffic initiator: writes Burst(a) over [first,last], reads it back
// in order and reports pass/fail, error count and the first failing address.
module qdr_usr_tester
  import qdr_usr_tester_pkg::*;
#(
  parameter int DATA_WIDTH      = QDR_DW,
  parameter int ADDR_WIDTH      = QDR_AW,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int RD_TIMEOUT      = 64
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   cfg_first_addr,
  input  logic [ADDR_WIDTH-1:0]   cfg_last_addr,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  input  logic                    phy_rdy,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic                    aborted,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic                    usr_wr_strb,
  output logic                    usr_rd_strb,
  output logic [31:0]             usr_addr,
  output logic [2*DATA_WIDTH-1:0] usr_wr_data,
  input  logic [2*DATA_WIDTH-1:0] usr_rd_data,
  input  logic                    usr_rd_dvld
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]           TO_LAST = 16'(RD_TIMEOUT - 1);

  state_t                  r_state;
  logic [ST_W-1:0]         r_status;
  logic [ADDR_WIDTH-1:0]   r_first;
  logic [ADDR_WIDTH-1:0]   r_last;
  logic [ADDR_WIDTH-1:0]   r_cur;
  logic [DATA_WIDTH-1:0]   r_seed;
  logic [15:0]             r_idle;
  logic [15:0]             r_err_count;
  logic [ADDR_WIDTH-1:0]   r_first_err;
  logic                    r_wr_strb;
  logic                    r_rd_strb;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [2*DATA_WIDTH-1:0] r_wr_data;

  logic                    w_idle;
  logic                    w_cfg_ok;
  logic                    w_start_ok;
  logic                    w_start_bad;
  logic                    w_abort;
  logic                    w_flush;
  logic                    w_push;
  logic [ADDR_WIDTH-1:0]   w_push_addr;
  logic                    w_chk;
  logic                    w_pop;
  logic                    w_mis;
  logic [ADDR_WIDTH-1:0]   w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [ADDR_WIDTH-1:0]   w_cur_inc;
  logic [15:0]             w_err_nxt;
  logic [ADDR_WIDTH-1:0]   w_first_nxt;

  assign busy           = r_status[ST_BUSY];
  assign done           = r_status[ST_DONE];
  assign pass           = r_status[ST_PASS];
  assign timeout        = r_status[ST_TIMEOUT];
  assign aborted        = r_status[ST_ABORTED];
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err;
  assign usr_wr_strb    = r_wr_strb;
  assign usr_rd_strb    = r_rd_strb;
  assign usr_addr       = {{(32-ADDR_WIDTH){1'b0}}, r_addr};
  assign usr_wr_data    = r_wr_data;

  qdr_usr_tester_fifo #(
    .WIDTH      (ADDR_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data (w_push_addr),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_idle      = (r_state == S_IDLE) || (r_state == S_DONE);
    w_cfg_ok    = phy_rdy && (cfg_first_addr <= cfg_last_addr);
    w_start_ok  = start && w_idle && w_cfg_ok;
    w_start_bad = start && w_idle && !w_cfg_ok;
    w_abort     = !phy_rdy && !w_idle;
    w_flush     = w_start_ok || w_start_bad || w_abort;
    w_cur_inc   = r_cur + A_ONE;
    w_chk       = usr_rd_dvld && ((r_state == S_READ) || (r_state == S_DRAIN));
    w_pop       = w_chk && !w_empty;
    w_mis       = w_chk && (w_empty || (usr_rd_data != burst(w_head, r_seed)));
  end

  // The first read of the range is pushed on the last write edge so READ starts without a gap.
  always_comb begin
    w_push      = 1'b0;
    w_push_addr = r_cur;
    if (phy_rdy && (r_state == S_WRITE) && (r_cur == r_last)) begin
      w_push      = 1'b1;
      w_push_addr = r_first;
    end else if (phy_rdy && (r_state == S_READ) && !w_full) begin
      w_push      = 1'b1;
      w_push_addr = r_cur;
    end else begin
      w_push      = 1'b0;
      w_push_addr = r_cur;
    end
  end

  always_comb begin
    w_err_nxt   = r_err_count;
    w_first_nxt = r_first_err;
    if (w_mis) begin
      if (r_err_count == 16'h0000) w_first_nxt = w_empty ? r_last : w_head;
      else                         w_first_nxt = r_first_err;
      if (r_err_count != 16'hFFFF) w_err_nxt = r_err_count + 16'h0001;
      else                         w_err_nxt = r_err_count;
    end else begin
      w_err_nxt   = r_err_count;
      w_first_nxt = r_first_err;
    end
  end

  // Test sequencer with registered bus and status outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_status    <= {ST_W{1'b0}};
      r_first     <= {ADDR_WIDTH{1'b0}};
      r_last      <= {ADDR_WIDTH{1'b0}};
      r_cur       <= {ADDR_WIDTH{1'b0}};
      r_seed      <= {DATA_WIDTH{1'b0}};
      r_idle      <= 16'h0000;
      r_err_count <= 16'h0000;
      r_first_err <= {ADDR_WIDTH{1'b0}};
      r_wr_strb   <= 1'b0;
      r_rd_strb   <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wr_data   <= {(2*DATA_WIDTH){1'b0}};
    end else begin
      r_err_count <= w_err_nxt;
      r_first_err <= w_first_nxt;
      if ((r_state == S_READ) || (r_state == S_DRAIN)) begin
        if (usr_rd_dvld)                r_idle <= 16'h0000;
        else if (r_idle != 16'hFFFF)    r_idle <= r_idle + 16'h0001;
      end
      if (w_abort) begin
        r_state   <= S_DONE;
        r_status  <= status_word(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        r_wr_strb <= 1'b0;
        r_rd_strb <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            r_wr_strb <= 1'b0;
            r_rd_strb <= 1'b0;
            if (w_start_ok) begin
              r_state     <= S_WRITE;
              r_status    <= status_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
              r_first     <= cfg_first_addr;
              r_last      <= cfg_last_addr;
              r_cur       <= cfg_first_addr;
              r_seed      <= cfg_seed;
              r_err_count <= 16'h0000;
              r_first_err <= {ADDR_WIDTH{1'b0}};
              r_wr_strb   <= 1'b1;
              r_addr      <= cfg_first_addr;
              r_wr_data   <= burst(cfg_first_addr, cfg_seed);
            end else if (w_start_bad) begin
              r_state     <= S_DONE;
              r_status    <= status_word(1'b0, 1'b1, 1'b0, 1'b0, !phy_rdy);
              r_err_count <= 16'h0000;
              r_first_err <= {ADDR_WIDTH{1'b0}};
            end
          end
          S_WRITE: begin
            if (r_cur == r_last) begin
              r_state   <= (r_first == r_last) ? S_DRAIN : S_READ;
              r_wr_strb <= 1'b0;
              r_rd_strb <= 1'b1;
              r_addr    <= r_first;
              r_cur     <= r_first + A_ONE;
              r_idle    <= 16'h0000;
            end else begin
              r_cur     <= w_cur_inc;
              r_addr    <= w_cur_inc;
              r_wr_data <= burst(w_cur_inc, r_seed);
            end
          end
          S_READ: begin
            if (!w_full) begin
              r_rd_strb <= 1'b1;
              r_addr    <= r_cur;
              if (r_cur == r_last) r_state <= S_DRAIN;
              else                 r_cur   <= w_cur_inc;
            end else begin
              r_rd_strb <= 1'b0;
            end
          end
          S_DRAIN: begin
            r_rd_strb <= 1'b0;
            if (w_empty) begin
              r_state  <= S_DONE;
              r_status <= status_word(1'b0, 1'b1, (w_err_nxt == 16'h0000), 1'b0, 1'b0);
            end else if (!usr_rd_dvld && (r_idle == TO_LAST)) begin
              r_state  <= S_DONE;
              r_status <= status_word(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_wr_strb <= 1'b0;
            r_rd_strb <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/qdr_usr_tester.md
Name: qdr_usr_tester

Overview:
Hardware traffic initiator for the QDR controller user port; it is the other end of usr_rd_strb/usr_wr_strb/usr_addr/usr_wr_data/usr_rd_data/usr_rd_dvld.
- Writes an address-derived pattern over a configured address range, reads the range back and checks every returned burst.
- Reports pass/fail, an error count and the first failing address.
- Sits beside the QDR controller in board test gateware, in the wb_clk_i (div_clk) domain; once phy_rdy asserts it qualifies calibration without CPU traffic.

Parameters:
DATA_WIDTH, 36, QDR data width; user bursts are 2*DATA_WIDTH
ADDR_WIDTH, 22, significant QDR address bits
FIFO_DEPTH_LOG2, 4, log2 depth of the outstanding-read address FIFO (16 entries)
RD_TIMEOUT, 64, idle cycles without usr_rd_dvld in DRAIN before declaring timeout

Ports:
wb_clk_i  in  1  sole clock, same clock as the controller user port
wb_rst_i  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a test when in IDLE or DONE
cfg_first_addr  in  ADDR_WIDTH  first address, sampled on start
cfg_last_addr  in  ADDR_WIDTH  last address inclusive, sampled on start
cfg_seed  in  DATA_WIDTH  pattern seed, sampled on start
phy_rdy  in  1  controller PHY ready
busy  out  1  test in progress
done  out  1  test finished; held until next accepted start
pass  out  1  valid when done
timeout  out  1  DRAIN timed out
aborted  out  1  phy_rdy dropped mid-test
err_count  out  16  mismatching bursts, saturating
first_err_addr  out  ADDR_WIDTH  address of first mismatch
usr_wr_strb  out  1  write request
usr_rd_strb  out  1  read request
usr_addr  out  32  request address, zero-extended from ADDR_WIDTH
usr_wr_data  out  2*DATA_WIDTH  write burst
usr_rd_data  in  2*DATA_WIDTH  read burst
usr_rd_dvld  in  1  read data valid, in request order

Behaviour:
Pattern and reset
- P(a) = zero_ext(a, DATA_WIDTH) XOR seed.
- Burst(a) = {~P(a), P(a)}: low half P, high half ~P.
- Reset values: busy=0, done=0, pass=0, timeout=0, aborted=0, err_count=0, first_err_addr=0, both strobes 0, usr_addr=0, usr_wr_data=0. The FIFO is flushed and the state is IDLE.
- All outputs are registered.

FSM: IDLE, WRITE, READ, DRAIN, DONE
- IDLE/DONE + start:
  - If phy_rdy=0 or first>last: go to DONE next cycle with pass=0 and no bus activity. aborted=1 if phy_rdy=0.
  - Otherwise: clear all status, set busy=1, go to WRITE. The first usr_wr_strb is on the cycle after start.
- start while busy is ignored.
- WRITE: one strobe per cycle, addr first..last, usr_wr_data=Burst(addr). After last, go to READ with no gap cycle.
- READ: one usr_rd_strb per cycle while the FIFO is not full; each issued address is pushed. FIFO full: no strobe that cycle, address held. After last is issued, go to DRAIN.
- usr_wr_strb and usr_rd_strb are never asserted in the same cycle.
- Check, active in READ and DRAIN: on usr_rd_dvld, pop the FIFO head and compare usr_rd_data with Burst(head).
  - On mismatch: err_count+1, saturating at 16'hFFFF; first_err_addr captured only when err_count was 0.
  - Push and pop in the same cycle are legal, and occupancy is unchanged.
  - usr_rd_dvld with the FIFO empty counts as one error; first_err_addr is captured as cfg_last_addr.
- DRAIN:
  - FIFO empty: go to DONE.
  - The idle counter resets on each dvld. On reaching RD_TIMEOUT: timeout=1, go to DONE.
- Abort: phy_rdy=0 in WRITE/READ/DRAIN sets aborted=1 and goes to DONE the next cycle. No further strobes; the FIFO is flushed.
- DONE: busy=0, done=1, pass = (err_count==0 && !timeout && !aborted). usr_rd_dvld in DONE or IDLE is ignored.
- wb_rst_i mid-test returns every output to its reset value on the next edge.

Decomposition:
- Package qdr_usr_tester_pkg holds:
  - state enum
  - pattern function Burst(a, seed)
  - status bit constants
- One sub-module, qdr_usr_tester_fifo: synchronous FIFO of ADDR_WIDTH × 2^FIFO_DEPTH_LOG2 with full/empty flags and simultaneous push/pop.
- The FSM, counters and comparator stay in the top.

Test Plan:
- Loopback memory model, latency 8; first=0, last=15, seed=0: 16 writes then 16 reads; write to addr 5 carries {36'hFFFFFFFFA, 36'h000000005}; done=1, pass=1, err_count=0.
- Model flips bit 0 of read data at addr 0x3 and 0x9; range 0..15: err_count=2, first_err_addr=0x3, pass=0.
- Model latency 40, range 0..63: FIFO fills and usr_rd_strb gaps appear with at most 16 outstanding; all data checks; pass=1.
- Model drops the last read response: timeout=1 exactly RD_TIMEOUT (64) cycles after the previous dvld; pass=0.
- phy_rdy low in WRITE at addr 7: aborted=1, no strobe after that cycle, done=1, pass=0; then start with first=10, last=9: immediate done, pass=0, no strobes.
- wb_rst_i pulsed mid-READ: all outputs return to reset values; a new start runs a clean test to pass=1.
